// File: rtl/dpc_corrector_mc.sv
// dpc_corrector_mc: 3-stage defective pixel corrector with mean and
// directional interpolation, frame-shadowed controls and per-frame stats.
module dpc_corrector_mc #(
    parameter int WIDTH     = 16,
    parameter int K_WIDTH   = 16,
    parameter int CNT_WIDTH = 20
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic [WIDTH-1:0]     s_axis_tdata,
    input  logic                 s_axis_tuser,
    input  logic                 s_axis_tlast,
    input  logic [8*WIDTH-1:0]   win_data,
    input  logic [7:0]           win_vld,
    input  logic [K_WIDTH:0]     k_tdata,
    input  logic [1:0]           mode,
    input  logic                 enable,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [WIDTH-1:0]     m_axis_tdata,
    output logic                 m_axis_tuser,
    output logic                 m_axis_tlast,
    output logic [CNT_WIDTH-1:0] stat_corrected,
    output logic [CNT_WIDTH-1:0] stat_unfixable,
    output logic                 stat_valid
);

    localparam int SW = WIDTH + 4;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    // only the bad flag of the k sideband is consumed here
    logic unused_k;
    assign unused_k = ^k_tdata[K_WIDTH-1:0];

    logic ce;
    logic acc;
    logic v1;
    logic v2;
    logic v3;

    assign ce            = !v3 || m_axis_tready;
    assign s_axis_tready = ce;
    assign acc           = s_axis_tvalid && ce;
    assign m_axis_tvalid = v3;

    // frame shadows; the SOF beat itself already uses the new values
    logic [1:0] sh_mode;
    logic       sh_en;
    logic [1:0] mode_eff;
    logic       en_eff;

    assign mode_eff = s_axis_tuser ? mode : sh_mode;
    assign en_eff   = s_axis_tuser ? enable : sh_en;

    // capture mode/enable on each accepted SOF beat
    always_ff @(posedge aclk) begin
        if (areset) begin
            sh_mode <= 2'd0;
            sh_en   <= 1'b0;
        end else if (acc && s_axis_tuser) begin
            sh_mode <= mode;
            sh_en   <= enable;
        end
    end

    // ---------------- stage 1: input registers ----------------
    logic [WIDTH-1:0]   c1;
    logic               u1;
    logic               l1;
    logic [8*WIDTH-1:0] win1;
    logic [7:0]         vld1;
    logic               fix1;
    logic               dir1;

    // stage-1 valid
    always_ff @(posedge aclk) begin
        if (areset) begin
            v1 <= 1'b0;
        end else if (ce) begin
            v1 <= s_axis_tvalid;
        end
    end

    // stage-1 payload, with correction decision pre-decoded
    always_ff @(posedge aclk) begin
        if (ce) begin
            c1   <= s_axis_tdata;
            u1   <= s_axis_tuser;
            l1   <= s_axis_tlast;
            win1 <= win_data;
            vld1 <= win_vld;
            fix1 <= k_tdata[K_WIDTH] && en_eff && (mode_eff != 2'd0);
            dir1 <= (mode_eff == 2'd2);
        end
    end

    // ---------------- stage 2: candidates ----------------
    logic [3:0]    n_c;
    logic [SW-1:0] sum_c;
    logic [SW-1:0] num_c;
    logic [SW-1:0] q_c;
    logic [WIDTH-1:0] mean_c;

    // neighbour count and sum of usable neighbours
    always_comb begin
        n_c   = 4'd0;
        sum_c = '0;
        for (int i = 0; i < 8; i++) begin
            if (vld1[i]) begin
                n_c   = n_c + 4'd1;
                sum_c = sum_c + SW'(win1[i*WIDTH +: WIDTH]);
            end
        end
    end

    assign num_c = sum_c + SW'(n_c >> 1);

    // rounded mean by constant divisors
    always_comb begin
        q_c = '0;
        unique case (n_c)
            4'd1:    q_c = num_c;
            4'd2:    q_c = num_c >> 1;
            4'd3:    q_c = num_c / SW'(3);
            4'd4:    q_c = num_c >> 2;
            4'd5:    q_c = num_c / SW'(5);
            4'd6:    q_c = num_c / SW'(6);
            4'd7:    q_c = num_c / SW'(7);
            4'd8:    q_c = num_c >> 3;
            default: q_c = '0;
        endcase
    end

    assign mean_c = WIDTH'(q_c);

    // pairs in tie-break priority order: H, V, D1, D2
    logic [3:0][WIDTH-1:0] pa;
    logic [3:0][WIDTH-1:0] pb;
    logic [3:0]            pv;

    // route window taps to pair members
    always_comb begin
        pa[0] = win1[3*WIDTH +: WIDTH];
        pb[0] = win1[4*WIDTH +: WIDTH];
        pv[0] = vld1[3] && vld1[4];
        pa[1] = win1[1*WIDTH +: WIDTH];
        pb[1] = win1[6*WIDTH +: WIDTH];
        pv[1] = vld1[1] && vld1[6];
        pa[2] = win1[0*WIDTH +: WIDTH];
        pb[2] = win1[7*WIDTH +: WIDTH];
        pv[2] = vld1[0] && vld1[7];
        pa[3] = win1[2*WIDTH +: WIDTH];
        pb[3] = win1[5*WIDTH +: WIDTH];
        pv[3] = vld1[2] && vld1[5];
    end

    logic             dok_c;
    logic [WIDTH-1:0] dir_c;
    logic [WIDTH-1:0] best_g;
    logic [WIDTH-1:0] g;
    logic [WIDTH:0]   s;

    // minimum-gradient pair; strict compare keeps earlier pair on ties
    always_comb begin
        dok_c  = 1'b0;
        dir_c  = '0;
        best_g = '0;
        g      = '0;
        s      = '0;
        for (int p = 0; p < 4; p++) begin
            g = (pa[p] > pb[p]) ? (pa[p] - pb[p]) : (pb[p] - pa[p]);
            s = {1'b0, pa[p]} + {1'b0, pb[p]} + (WIDTH+1)'(1);
            if (pv[p] && (!dok_c || (g < best_g))) begin
                dok_c  = 1'b1;
                best_g = g;
                dir_c  = WIDTH'(s >> 1);
            end
        end
    end

    logic [WIDTH-1:0] c2;
    logic             u2;
    logic             l2;
    logic             fix2;
    logic             dir2;
    logic             nz2;
    logic [WIDTH-1:0] mean2;
    logic             dok2;
    logic [WIDTH-1:0] dirv2;

    // stage-2 valid
    always_ff @(posedge aclk) begin
        if (areset) begin
            v2 <= 1'b0;
        end else if (ce) begin
            v2 <= v1;
        end
    end

    // stage-2 payload
    always_ff @(posedge aclk) begin
        if (ce) begin
            c2    <= c1;
            u2    <= u1;
            l2    <= l1;
            fix2  <= fix1;
            dir2  <= dir1;
            nz2   <= (n_c == 4'd0);
            mean2 <= mean_c;
            dok2  <= dok_c;
            dirv2 <= dir_c;
        end
    end

    // ---------------- stage 3: select and output ----------------
    logic [WIDTH-1:0] res_c;
    logic             corr_c;
    logic             unfx_c;

    // pick the final pixel and classify the beat for statistics
    always_comb begin
        res_c  = c2;
        corr_c = 1'b0;
        unfx_c = 1'b0;
        if (fix2) begin
            if (nz2) begin
                unfx_c = 1'b1;
            end else begin
                corr_c = 1'b1;
                res_c  = (dir2 && dok2) ? dirv2 : mean2;
            end
        end
    end

    logic corr3;
    logic unfx3;

    // output register; frozen while stalled
    always_ff @(posedge aclk) begin
        if (areset) begin
            v3           <= 1'b0;
            m_axis_tdata <= '0;
            m_axis_tuser <= 1'b0;
            m_axis_tlast <= 1'b0;
            corr3        <= 1'b0;
            unfx3        <= 1'b0;
        end else if (ce) begin
            v3           <= v2;
            m_axis_tdata <= res_c;
            m_axis_tuser <= u2;
            m_axis_tlast <= l2;
            corr3        <= corr_c;
            unfx3        <= unfx_c;
        end
    end

    // ---------------- statistics ----------------
    logic                 hs;
    logic                 sof_seen;
    logic [CNT_WIDTH-1:0] cnt_corr;
    logic [CNT_WIDTH-1:0] cnt_unfx;

    assign hs = v3 && m_axis_tready;

    // count at output handshake; SOF publishes and restarts
    always_ff @(posedge aclk) begin
        if (areset) begin
            sof_seen       <= 1'b0;
            cnt_corr       <= '0;
            cnt_unfx       <= '0;
            stat_corrected <= '0;
            stat_unfixable <= '0;
            stat_valid     <= 1'b0;
        end else begin
            stat_valid <= 1'b0;
            if (hs) begin
                if (m_axis_tuser) begin
                    sof_seen <= 1'b1;
                    cnt_corr <= CNT_WIDTH'(corr3);
                    cnt_unfx <= CNT_WIDTH'(unfx3);
                    if (sof_seen) begin
                        stat_corrected <= cnt_corr;
                        stat_unfixable <= cnt_unfx;
                        stat_valid     <= 1'b1;
                    end
                end else begin
                    if (corr3 && !(&cnt_corr)) begin
                        cnt_corr <= cnt_corr + CNT_ONE;
                    end
                    if (unfx3 && !(&cnt_unfx)) begin
                        cnt_unfx <= cnt_unfx + CNT_ONE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dpc_corrector_mc.sv
// tb_dpc_corrector_mc: vector table of single-beat frames plus
// sequences for latency, stats, shadowing, backpressure and reset.
module tb_dpc_corrector_mc;

    localparam int W  = 16;
    localparam int KW = 16;
    localparam int CW = 20;
    localparam int NV = 16;
    localparam int NB = 2560;

    logic          aclk = 1'b0;
    logic          areset;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [W-1:0]  s_axis_tdata;
    logic          s_axis_tuser;
    logic          s_axis_tlast;
    logic [8*W-1:0] win_data;
    logic [7:0]    win_vld;
    logic [KW:0]   k_tdata;
    logic [1:0]    mode;
    logic          enable;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [W-1:0]  m_axis_tdata;
    logic          m_axis_tuser;
    logic          m_axis_tlast;
    logic [CW-1:0] stat_corrected;
    logic [CW-1:0] stat_unfixable;
    logic          stat_valid;

    always #5 aclk = ~aclk;

    dpc_corrector_mc #(
        .WIDTH     (W),
        .K_WIDTH   (KW),
        .CNT_WIDTH (CW)
    ) dut (
        .aclk           (aclk),
        .areset         (areset),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tuser   (s_axis_tuser),
        .s_axis_tlast   (s_axis_tlast),
        .win_data       (win_data),
        .win_vld        (win_vld),
        .k_tdata        (k_tdata),
        .mode           (mode),
        .enable         (enable),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tuser   (m_axis_tuser),
        .m_axis_tlast   (m_axis_tlast),
        .stat_corrected (stat_corrected),
        .stat_unfixable (stat_unfixable),
        .stat_valid     (stat_valid)
    );

    typedef struct packed {
        logic [W-1:0] d;
        logic         u;
        logic         l;
    } beat_t;

    typedef struct {
        logic [W-1:0]   c;
        logic [8*W-1:0] win;
        logic [7:0]     vld;
        logic           bad;
        logic [1:0]     md;
        logic           en;
        logic [W-1:0]   exp;
    } vec_t;

    int    checks = 0;
    int    errors = 0;
    int    tr_mode = 1;
    beat_t outq[$];
    beat_t cur;
    beat_t prev_b;
    logic  prev_stall = 1'b0;
    int    hold_err = 0;
    int    out_cnt = 0;
    int    sv_cnt = 0;
    int    sv_corr = 0;
    int    sv_unfx = 0;
    vec_t  tbl[NV];

    assign cur = {m_axis_tdata, m_axis_tuser, m_axis_tlast};

    always @(posedge aclk) begin
        #1;
        case (tr_mode)
            0:       m_axis_tready = 1'b0;
            2:       m_axis_tready = ($urandom_range(0, 99) < 30);
            default: m_axis_tready = 1'b1;
        endcase
    end

    always @(negedge aclk) begin
        if (m_axis_tvalid && m_axis_tready) begin
            out_cnt <= out_cnt + 1;
            outq.push_back(cur);
        end
        if (stat_valid) begin
            sv_cnt  <= sv_cnt + 1;
            sv_corr <= int'(stat_corrected);
            sv_unfx <= int'(stat_unfixable);
        end
        if (areset) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (!m_axis_tvalid || cur != prev_b))
                hold_err <= hold_err + 1;
            prev_stall <= m_axis_tvalid && !m_axis_tready;
            prev_b     <= cur;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [8*W-1:0] pk(input int a, input int b,
                                          input int c, input int d,
                                          input int e, input int f,
                                          input int g, input int h);
        return {W'(h), W'(g), W'(f), W'(e), W'(d), W'(c), W'(b), W'(a)};
    endfunction

    function automatic vec_t mkv(input int c, input logic [8*W-1:0] win,
                                 input logic [7:0] vld, input logic bad,
                                 input logic [1:0] md, input logic en,
                                 input int exp);
        vec_t v;
        v.c   = W'(c);
        v.win = win;
        v.vld = vld;
        v.bad = bad;
        v.md  = md;
        v.en  = en;
        v.exp = W'(exp);
        return v;
    endfunction

    function automatic logic [W-1:0] pix(input int i);
        return W'(i * 37 + 5);
    endfunction

    task automatic send(input logic [W-1:0] c, input logic [8*W-1:0] win,
                        input logic [7:0] vld, input logic bad,
                        input logic [1:0] md, input logic en,
                        input logic u, input logic l);
        int t;
        s_axis_tdata  = c;
        win_data      = win;
        win_vld       = vld;
        k_tdata       = {bad, {KW{1'b0}}};
        mode          = md;
        enable        = en;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        t = 0;
        forever begin
            @(negedge aclk);
            if (s_axis_tready) break;
            t++;
            if (t > 2000) break;
        end
        if (t > 2000) chk("send_timeout", t, 0);
        @(posedge aclk);
        #1;
    endtask

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic wait_q(input int n, input string name);
        int t;
        t = 0;
        while (outq.size() < n && t < 30000) begin
            @(posedge aclk);
            t++;
        end
        #1;
        chk(name, outq.size(), n);
    endtask

    task automatic do_reset();
        areset = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
    endtask

    task automatic bp_run(input int trm, input string tag);
        int    nbad;
        int    nlast;
        beat_t e;
        outq.delete();
        tr_mode = trm;
        for (int i = 0; i < NB; i++) begin
            send(pix(i), pk(200, 200, 200, 200, 200, 200, 200, 200),
                 8'hFF, (i % 7) == 3, 2'd1, 1'b1, i == 0,
                 (i % 640) == 639);
        end
        idle(1);
        wait_q(NB, {tag, "_count"});
        nbad  = 0;
        nlast = 0;
        for (int i = 0; i < outq.size() && i < NB; i++) begin
            e.d = ((i % 7) == 3) ? W'(200) : pix(i);
            e.u = (i == 0);
            e.l = ((i % 640) == 639);
            if (outq[i] != e) nbad++;
            if (outq[i].l) nlast++;
        end
        chk({tag, "_seq"}, nbad, 0);
        chk({tag, "_tlast"}, nlast, 4);
        tr_mode = 1;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8*W-1:0] full;
        logic [8*W-1:0] wins;
        int lat;
        int base;
        int oc;

        full = pk(100, 102, 104, 106, 108, 110, 112, 114);
        wins = pk(0, 0, 0, 10, 12, 0, 100, 0);

        tbl[0]  = mkv(0,   full, 8'hFF, 1'b1, 2'd1, 1'b1, 107);
        tbl[1]  = mkv(0,   pk(0, 10, 0, 50, 52, 0, 90, 0),
                      8'h5A, 1'b1, 2'd2, 1'b1, 51);
        tbl[2]  = mkv(0,   pk(0, 60, 0, 40, 44, 0, 64, 0),
                      8'h5A, 1'b1, 2'd2, 1'b1, 42);
        tbl[3]  = mkv(999, pk(1, 2, 3, 4, 5, 6, 7, 8),
                      8'h00, 1'b1, 2'd1, 1'b1, 999);
        tbl[4]  = mkv(500, full, 8'hFF, 1'b1, 2'd1, 1'b0, 500);
        tbl[5]  = mkv(501, full, 8'hFF, 1'b1, 2'd0, 1'b1, 501);
        tbl[6]  = mkv(502, full, 8'hFF, 1'b1, 2'd3, 1'b1, 107);
        tbl[7]  = mkv(77,  full, 8'hFF, 1'b0, 2'd1, 1'b1, 77);
        tbl[8]  = mkv(600, pk(10, 20, 31, 1000, 1000, 1000, 1000, 1000),
                      8'h07, 1'b1, 2'd1, 1'b1, 20);
        tbl[9]  = mkv(601, pk(10, 15, 0, 0, 0, 0, 0, 0),
                      8'h03, 1'b1, 2'd2, 1'b1, 13);
        tbl[10] = mkv(602, pk(0, 0, 300, 5, 500, 310, 0, 1000),
                      8'hBD, 1'b1, 2'd2, 1'b1, 305);
        tbl[11] = mkv(603, pk(10, 11, 12, 13, 14, 15, 20, 0),
                      8'h7F, 1'b1, 2'd1, 1'b1, 14);
        tbl[12] = mkv(604, pk(65535, 65535, 65535, 65535, 65535, 0, 0, 0),
                      8'h1F, 1'b1, 2'd1, 1'b1, 65535);
        tbl[13] = mkv(605, pk(0, 0, 0, 65535, 65535, 0, 0, 0),
                      8'h18, 1'b1, 2'd2, 1'b1, 65535);
        tbl[14] = mkv(606, pk(1, 2, 0, 0, 0, 0, 0, 0),
                      8'h03, 1'b1, 2'd1, 1'b1, 2);
        tbl[15] = mkv(607, pk(0, 0, 0, 0, 0, 0, 0, 4321),
                      8'h80, 1'b1, 2'd1, 1'b1, 4321);

        areset        = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
        win_data      = '0;
        win_vld       = '0;
        k_tdata       = '0;
        mode          = 2'd0;
        enable        = 1'b0;

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_s_tready", int'(s_axis_tready), 1);
        chk("rst_m_tvalid", int'(m_axis_tvalid), 0);
        chk("rst_m_tdata", int'(m_axis_tdata), 0);
        chk("rst_m_tuser", int'(m_axis_tuser), 0);
        chk("rst_stat_corr", int'(stat_corrected), 0);
        chk("rst_stat_unfx", int'(stat_unfixable), 0);
        chk("rst_stat_valid", int'(stat_valid), 0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        repeat (2) @(posedge aclk);
        #1;

        send(tbl[0].c, tbl[0].win, tbl[0].vld, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1);
        s_axis_tvalid = 1'b0;
        lat = 0;
        do begin
            @(negedge aclk);
            lat++;
        end while (!m_axis_tvalid && lat < 20);
        chk("latency", lat, 3);
        chk("latency_data", int'(m_axis_tdata), 107);
        @(posedge aclk);
        #1;
        outq.delete();

        for (int i = 0; i < NV; i++) begin
            send(tbl[i].c, tbl[i].win, tbl[i].vld, tbl[i].bad,
                 tbl[i].md, tbl[i].en, 1'b1, 1'b1);
        end
        idle(1);
        wait_q(NV, "tbl_count");
        for (int i = 0; i < NV && i < outq.size(); i++) begin
            chk($sformatf("tbl%0d_data", i), int'(outq[i].d),
                int'(tbl[i].exp));
        end

        do_reset();
        base = sv_cnt;
        send(999, '0, 8'h00, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0);
        send(0, full, 8'hFF, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
        send(7, full, 8'hFF, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0);
        send(888, '0, 8'h00, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1);
        idle(6);
        chk("first_sof_no_pulse", sv_cnt - base, 0);
        send(0, full, 8'hFF, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0);
        send(777, '0, 8'h00, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1);
        idle(6);
        chk("stat1_pulses", sv_cnt - base, 1);
        chk("stat1_corr", sv_corr, 1);
        chk("stat1_unfx", sv_unfx, 2);
        send(5, full, 8'hFF, 1'b0, 2'd1, 1'b1, 1'b1, 1'b1);
        idle(6);
        chk("stat2_pulses", sv_cnt - base, 2);
        chk("stat2_corr", sv_corr, 1);
        chk("stat2_unfx", sv_unfx, 1);
        chk("stat2_hold", int'(stat_unfixable), 1);

        outq.delete();
        send(1, wins, 8'h5A, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0);
        send(200, wins, 8'h5A, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1);
        send(201, wins, 8'h5A, 1'b1, 2'd2, 1'b1, 1'b1, 1'b1);
        idle(1);
        wait_q(3, "shadow_count");
        if (outq.size() >= 3) begin
            chk("shadow_sof", int'(outq[0].d), 1);
            chk("shadow_midframe", int'(outq[1].d), 31);
            chk("shadow_next_sof", int'(outq[2].d), 11);
        end

        bp_run(1, "nostall");
        bp_run(2, "stall");
        chk("hold_stable", hold_err, 0);

        tr_mode = 0;
        @(posedge aclk);
        #2;
        send(11, full, 8'hFF, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0);
        send(12, full, 8'hFF, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
        idle(2);
        oc = out_cnt;
        do_reset();
        tr_mode = 1;
        repeat (10) @(posedge aclk);
        #1;
        chk("rst_mid_no_out", out_cnt - oc, 0);
        chk("rst_mid_tvalid", int'(m_axis_tvalid), 0);
        chk("rst_mid_corr", int'(stat_corrected), 0);
        chk("rst_mid_unfx", int'(stat_unfixable), 0);

        base = sv_cnt;
        outq.delete();
        send(321, full, 8'hFF, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
        send(123, full, 8'hFF, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1);
        idle(1);
        wait_q(2, "post_rst_count");
        if (outq.size() >= 2) begin
            chk("pre_sof_shadow_off", int'(outq[0].d), 321);
            chk("post_rst_sof", int'(outq[1].d), 107);
        end
        idle(4);
        chk("post_rst_no_pulse", sv_cnt - base, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dpc_corrector_mc.md
DPC_CORRECTOR_MC -- requirements
Module: dpc_corrector_mc

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the pixel width.
REQ-002 The block SHALL have parameter K_WIDTH, default 16, giving the k value width; k_tdata is K_WIDTH+1 bits wide.
REQ-003 The block SHALL have parameter CNT_WIDTH, default 20, giving the statistics counter width.
REQ-004 aclk  in  1  single clock, rising-edge.
REQ-005 areset  in  1  reset; synchronous, active-high.
REQ-006 s_axis_tvalid/tready/tdata/tuser/tlast  in/out/in/in/in  1/1/WIDTH/1/1  centre pixel stream (w22); tuser marks SOF, tlast marks EOL.
REQ-007 win_data  in  8*WIDTH  neighbours packed LSB-first: w11,w12,w13,w21,w23,w31,w32,w33.
REQ-008 win_vld  in  8  per-neighbour good flag in the same order; 1 = usable.
REQ-009 k_tdata  in  K_WIDTH+1  MSB = centre bad flag; sideband qualified by s_axis_tvalid.
REQ-010 mode  in  2  correction mode: 0 pass, 1 mean, 2 directional, 3 reserved (treated as 1).
REQ-011 enable  in  1  correction enable.
REQ-012 m_axis_tvalid/tready/tdata/tuser/tlast  out/in/out/out/out  1/1/WIDTH/1/1  corrected stream.
REQ-013 stat_corrected  out  CNT_WIDTH  bad pixels corrected in the previous frame.
REQ-014 stat_unfixable  out  CNT_WIDTH  bad pixels with no usable neighbour in the previous frame.
REQ-015 stat_valid  out  1  one-cycle pulse when the stat_* outputs update.

Function
REQ-016 The datapath SHALL be a 3-stage pipeline with one common advance enable, ce = !v3 | m_axis_tready, where v3 is the stage-3 valid bit; s_axis_tready SHALL equal ce.
- Stage 1: register inputs.
- Stage 2: compute candidates.
- Stage 3: select and output.
REQ-017 Latency SHALL be exactly 3 cycles from an accepted input beat to m_axis_tvalid when there is no stall; a stall freezes all stages and loses no beat.
REQ-018 Pipeline bubbles SHALL propagate as tvalid=0.
- tuser and tlast SHALL travel aligned with their data.
- Data, tuser and tlast SHALL be held stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-019 mode and enable SHALL be sampled on the accepted SOF beat into shadow registers that are used for the whole frame; before the first SOF the shadows SHALL be mode 0 and enable 0.
REQ-020 The correction rule SHALL apply only when the centre is bad and the enable shadow is 1; otherwise output = w22.
REQ-021 Mean mode: n = popcount(win_vld) and S = sum of the valid neighbours (WIDTH+3 bits). The result SHALL be floor((S + floor(n/2)) / n), exact for every n in 1..8.
REQ-022 Directional mode SHALL evaluate four neighbour pairs:
- H = (w21, w23)
- V = (w12, w32)
- D1 = (w11, w33)
- D2 = (w13, w31)
A pair is a candidate only when both of its members are valid, and its gradient is |a-b|.
- The pair with the minimum gradient SHALL be chosen; ties SHALL resolve with priority H>V>D1>D2.
- The result SHALL be (a+b+1)>>1.
- When no pair is a candidate, the mean-mode result SHALL be used.
REQ-023 When the centre is bad and n=0, output SHALL be the original w22 and stat_unfixable SHALL increment; otherwise a correction SHALL increment the corrected counter.
REQ-024 All results SHALL fit in WIDTH bits without overflow; no saturation logic is needed.
REQ-025 Counters SHALL count at the stage-3 output handshake.
- On the output handshake of an SOF beat, the counts accumulated so far SHALL copy to the stat_* outputs and stat_valid SHALL pulse, except on the first SOF after reset.
- The counters SHALL restart, counting that SOF beat itself.
REQ-026 Counters SHALL saturate at all-ones.

Reset
REQ-027 Under areset the following SHALL clear to 0: all valid bits, m_axis_tdata/tuser/tlast, counters, stat_*, stat_valid, and the shadows (mode 0, enable 0). s_axis_tready SHALL read 1 during and after reset.
REQ-028 An areset asserted mid-frame SHALL discard in-flight beats; the next frame starts clean.

Verification
REQ-029 Mean: enable=1, mode=1, bad centre, neighbours 100,102,104,106,108,110,112,114 with win_vld=0xFF -> output 107 at 3 cycles.
REQ-030 Directional: H=(50,52), V=(10,90), D1 and D2 invalid -> H chosen, output 51; H=(40,44) with V=(60,64) -> tie, H wins, output 42.
REQ-031 Unfixable: bad centre w22=999 with win_vld=0 -> output 999; stat_unfixable=1 after the next SOF together with a stat_valid pulse.
REQ-032 Backpressure: random m_axis_tready at 30% duty over a 640x4 frame -> output sequence identical to the no-stall run, with no drops or duplicates and tlast count 4.
REQ-033 Shadowing: mode changed from 1 to 2 mid-frame -> no effect until the next SOF beat.
REQ-034 Reset mid-frame with 2 beats in flight -> no output beats after reset; stat_* = 0.
